// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object-table DMA engine.
//   dma_state_e : controller states (idle, bus request, transfer, drain, release)
//   OBJ_BASE    : main-RAM base of the object table (CPU view)
//   OBJ_AW      : object-table offset width
package jtpopeye_pkg;

  localparam logic [15:0] OBJ_BASE = 16'h8C00;
  localparam int unsigned OBJ_AW   = 10;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StDrain,
    StRel
  } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_pipe.sv
// Address/valid delay line matching the main-RAM read latency.
// An address entered with valid_i appears on addr_o/valid_o Lat clocks later,
// aligned with the read data it fetched.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : drop every in-flight entry (bus lost)
//   valid_i    : a new address is being presented this clock
//   addr_i     : current RAM offset
//   valid_o    : delayed valid (write strobe source)
//   addr_o     : delayed offset (write address)
module jtpopeye_dma_pipe
  import jtpopeye_pkg::*;
#(
  parameter int unsigned Lat = 2,
  parameter int unsigned Aw  = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [Aw-1:0] addr_i,
  output logic          valid_o,
  output logic [Aw-1:0] addr_o
);

  logic [Lat-1:0]         valid_q;
  logic [Lat-1:0][Aw-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q[0] <= valid_i & ~flush_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < int'(Lat); i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Lat-1];
  assign addr_o  = addr_q[Lat-1];

endmodule

// File: rtl/jtpopeye_obj_dma.sv
// Object-table DMA: on each vertical-blank rising edge, take the Z80 bus and
// copy main RAM 0x8C00.. (DMA_LEN bytes) into the object line-buffer RAM.
// Optional macro JTPOPEYE_DMA_TIMEOUT_EN: give up after TMO_CYC clocks
// without bus grant and raise the sticky dma_err_o flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   dma_cen_i    : address advance enable
//   vb_i         : vertical blank level
//   busrq_n_o    : Z80 bus request (active low); busak_n_i : acknowledge
//   dma_cs_o     : main RAM address mux select; ad_dma_o : RAM offset
//   dd_dma_i     : RAM read data
//   obj_addr_o/obj_data_o/obj_we_o : object buffer write port
//   dma_busy_o, dma_done_o, dma_err_o : status
module jtpopeye_obj_dma
  import jtpopeye_pkg::*;
#(
  parameter int unsigned DMA_LEN = 1024,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned TMO_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_cen_i,
  input  logic              vb_i,
  output logic              busrq_n_o,
  input  logic              busak_n_i,
  output logic              dma_cs_o,
  output logic [OBJ_AW-1:0] ad_dma_o,
  input  logic [7:0]        dd_dma_i,
  output logic [OBJ_AW-1:0] obj_addr_o,
  output logic [7:0]        obj_data_o,
  output logic              obj_we_o,
  output logic              dma_busy_o,
  output logic              dma_done_o,
  output logic              dma_err_o
);

  // One counter serves both the drain wait and the grant timeout.
  localparam int unsigned CntMax = (TMO_CYC > RAM_LAT) ? TMO_CYC : RAM_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [OBJ_AW-1:0] LastAddr  = OBJ_AW'(DMA_LEN - 1);
  localparam logic [CntW-1:0]   DrainLast = CntW'(RAM_LAT - 1);

  dma_state_e        st_q, st_d;
  logic              vbl_q;
  logic              busrq_n_q, busrq_n_d;
  logic              cs_q, cs_d;
  logic [OBJ_AW-1:0] ad_q, ad_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              new_q, new_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              vb_edge, abort, pipe_valid;

  assign vb_edge = vb_i & ~vbl_q;
  // Bus taken back while we still drive the RAM mux.
  assign abort   = ((st_q == StXfer) || (st_q == StDrain)) && busak_n_i;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYC - 1);
  logic err_q, err_d;
`endif

  always_comb begin
    st_d      = st_q;
    busrq_n_d = busrq_n_q;
    cs_d      = cs_q;
    ad_d      = ad_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    new_d     = 1'b0;
    cnt_d     = cnt_q;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (st_q)
      StIdle: begin
        if (vb_edge) begin
          busrq_n_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          st_d      = StReq;
        end
      end
      StReq: begin
        if (!busak_n_i) begin
          cs_d  = 1'b1;
          ad_d  = '0;
          new_d = 1'b1;
          cnt_d = '0;
          st_d  = (LastAddr == '0) ? StDrain : StXfer;
        end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        else if (cnt_q == TmoLast) begin
          busrq_n_d = 1'b1;
          err_d     = 1'b1;
          st_d      = StRel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StXfer: begin
        if (abort) begin
          cs_d      = 1'b0;
          busrq_n_d = 1'b1;
          st_d      = StRel;
        end else if (dma_cen_i) begin
          ad_d  = ad_q + 1'b1;
          new_d = 1'b1;
          // Presenting the final offset starts the drain wait.
          if (ad_q == LastAddr - 1'b1) begin
            cnt_d = '0;
            st_d  = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          cs_d      = 1'b0;
          busrq_n_d = 1'b1;
          st_d      = StRel;
        end else if (cnt_q == DrainLast) begin
          cs_d      = 1'b0;
          busrq_n_d = 1'b1;
          st_d      = StRel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRel: begin
        if (busak_n_i) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          st_d   = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StIdle;
      vbl_q     <= 1'b0;
      busrq_n_q <= 1'b1;
      cs_q      <= 1'b0;
      ad_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      new_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      vbl_q     <= vb_i;
      busrq_n_q <= busrq_n_d;
      cs_q      <= cs_d;
      ad_q      <= ad_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      new_q     <= new_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign dma_err_o = err_q;
`else
  assign dma_err_o = 1'b0;
`endif

  jtpopeye_dma_pipe #(
    .Lat (RAM_LAT),
    .Aw  (OBJ_AW)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort),
    .valid_i (new_q),
    .addr_i  (ad_q),
    .valid_o (pipe_valid),
    .addr_o  (obj_addr_o)
  );

  // Suppress the write on the abort clock itself; the flush covers the rest.
  assign obj_we_o   = pipe_valid & ~abort;
  assign obj_data_o = obj_we_o ? dd_dma_i : 8'h00;

  assign busrq_n_o  = busrq_n_q;
  assign dma_cs_o   = cs_q;
  assign ad_dma_o   = ad_q;
  assign dma_busy_o = busy_q;
  assign dma_done_o = done_q;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
module tb_jtpopeye_obj_dma;
  import jtpopeye_pkg::*;

  localparam int DMA_LEN = 1024;
  localparam int RAM_LAT = 2;
  localparam int TMO_CYC = 4095;

  logic       clk, rst_n, dma_cen, vb, busrq_n, busak_n, dma_cs;
  logic [9:0] ad_dma, obj_addr;
  logic [7:0] dd_dma, obj_data;
  logic       obj_we, dma_busy, dma_done, dma_err;

  jtpopeye_obj_dma #(
    .DMA_LEN (DMA_LEN),
    .RAM_LAT (RAM_LAT),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_cen_i  (dma_cen),
    .vb_i       (vb),
    .busrq_n_o  (busrq_n),
    .busak_n_i  (busak_n),
    .dma_cs_o   (dma_cs),
    .ad_dma_o   (ad_dma),
    .dd_dma_i   (dd_dma),
    .obj_addr_o (obj_addr),
    .obj_data_o (obj_data),
    .obj_we_o   (obj_we),
    .dma_busy_o (dma_busy),
    .dma_done_o (dma_done),
    .dma_err_o  (dma_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main RAM: registered address, synchronous read (two clocks of latency).
  logic [7:0]  mem [0:65535];
  logic [15:0] ram_a;
  logic [7:0]  ram_q;
  always @(posedge clk) begin
    ram_a <= dma_cs ? (OBJ_BASE + {6'd0, ad_dma}) : 16'h0000;
    ram_q <= mem[ram_a];
  end
  assign dd_dma = ram_q;

  int total = 0;
  int bad   = 0;

  // Observations gathered during one frame.
  int wr_a[$];
  int wr_d[$];
  int done_cnt, viol, issue_cyc, cs_low_cyc, abort_cyc, we_after_abort, rq_low;
  logic cs_after_abort, err_exp, reset_hit, ended;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < DMA_LEN; i++)
      mem[int'(OBJ_BASE) + i] = rnd ? 8'($urandom) : i[7:0];
    mem[0] = 8'h00;
  endtask

  // Runs one VB-triggered frame, playing the Z80 bus arbiter.
  // grant_dly < 0: never grant. cen_per == 0: random dma_cen.
  task automatic run_frame(input string tag, input int grant_dly, input int cen_per,
                           input int abort_at, input int vb2_at, input int rst_at,
                           input int budget);
    int cyc = 0, gcnt = 0, post = 0, vb2_cyc = -1;
    bit aborted = 0;
    wr_a.delete(); wr_d.delete();
    done_cnt = 0; viol = 0; issue_cyc = -1; cs_low_cyc = -1; abort_cyc = -1;
    we_after_abort = 0; rq_low = 0; cs_after_abort = 1'bx; reset_hit = 0; ended = 0;
    @(negedge clk);
    vb = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (obj_we) begin
        wr_a.push_back(int'(obj_addr));
        wr_d.push_back(int'(obj_data));
        if (aborted && cyc > abort_cyc) we_after_abort++;
      end
      if (dma_done) done_cnt++;
      if (dma_cs && busak_n) viol++;
      if (dma_cs && int'(ad_dma) == DMA_LEN - 1 && issue_cyc < 0) issue_cyc = cyc;
      if (issue_cyc >= 0 && !dma_cs && cs_low_cyc < 0) cs_low_cyc = cyc;
      if (aborted && cyc == abort_cyc + 1) cs_after_abort = dma_cs;
      if (!busrq_n) rq_low++;
      if (done_cnt > 0) post++;
      if (post >= 20) begin
        ended = 1;
        break;
      end
      if (vb2_at >= 0 && vb2_cyc < 0 && dma_cs && int'(ad_dma) == vb2_at) vb2_cyc = cyc;
      vb = (cyc < 3) || (vb2_cyc >= 0 && cyc < vb2_cyc + 3);
      if (abort_at >= 0 && !aborted && dma_cs && int'(ad_dma) == abort_at) begin
        aborted = 1;
        abort_cyc = cyc;
      end
      if (aborted || busrq_n) begin
        busak_n = 1'b1;
        gcnt = 0;
      end else if (grant_dly >= 0 && gcnt >= grant_dly) begin
        busak_n = 1'b0;
      end else begin
        gcnt++;
      end
      dma_cen = (cen_per == 0) ? 1'($urandom) : ((cyc % cen_per) == 0);
      if (rst_at >= 0 && dma_cs && int'(ad_dma) == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_async_busrq"}, busrq_n, 1);
        chk({tag, "_async_cs"}, dma_cs, 0);
        chk({tag, "_async_we"}, obj_we, 0);
        chk({tag, "_async_ad"}, ad_dma, 0);
        reset_hit = 1;
        ended = 1;
        break;
      end
    end
    chk({tag, "_ended"}, ended, 1);
  endtask

  task automatic check_full(input string tag);
    int mism = 0;
    for (int i = 0; i < wr_a.size(); i++)
      if (wr_a[i] != i || wr_d[i] != int'(mem[int'(OBJ_BASE) + i])) mism++;
    chk({tag, "_we_count"}, wr_a.size(), DMA_LEN);
    chk({tag, "_data_order"}, mism, 0);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busrq_rel"}, busrq_n, 1);
    chk({tag, "_busy_clr"}, dma_busy, 0);
    chk({tag, "_cs_vs_busak"}, viol, 0);
    chk({tag, "_err"}, dma_err, err_exp);
  endtask

  initial begin
    int mism;
    rst_n = 1'b0; vb = 1'b0; dma_cen = 1'b0; busak_n = 1'b1; err_exp = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busrq", busrq_n, 1);
    chk("rst_cs", dma_cs, 0);
    chk("rst_ad", ad_dma, 0);
    chk("rst_obj_addr", obj_addr, 0);
    chk("rst_obj_data", obj_data, 0);
    chk("rst_we", obj_we, 0);
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_err", dma_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Incrementing pattern, grant after 5 clocks, dma_cen every clock.
    fill(0);
    run_frame("f1", 5, 1, -1, -1, -1, 3000);
    check_full("f1");
    chk("f1_cs_drop", cs_low_cyc - issue_cyc, RAM_LAT);

    // Random data, dma_cen every third clock.
    fill(1);
    run_frame("f2", int'($urandom_range(1, 8)), 3, -1, -1, -1, 6000);
    check_full("f2");
    chk("f2_cs_drop", cs_low_cyc - issue_cyc, RAM_LAT);

    // Second VB edge mid-transfer is ignored.
    fill(1);
    run_frame("vb2", int'($urandom_range(0, 6)), 1, -1, 100, -1, 3000);
    check_full("vb2");

    // Bus taken back at offset 300.
    fill(1);
    run_frame("abt", int'($urandom_range(0, 6)), 1, 300, -1, -1, 3000);
    mism = 0;
    for (int i = 0; i < wr_a.size(); i++)
      if (wr_a[i] != i || wr_d[i] != int'(mem[int'(OBJ_BASE) + i])) mism++;
    chk("abt_prefix", mism, 0);
    chk("abt_bound", wr_a.size() <= 301 && wr_a.size() >= 300 - RAM_LAT - 1, 1);
    chk("abt_cs_same_clk", cs_after_abort, 0);
    chk("abt_no_we_after", we_after_abort, 0);
    chk("abt_done_once", done_cnt, 1);
    chk("abt_busrq_rel", busrq_n, 1);

    // Reset mid-transfer, then a clean frame from offset 0.
    fill(1);
    run_frame("rst", int'($urandom_range(0, 6)), 1, -1, -1, 512, 3000);
    chk("rst_hit", reset_hit, 1);
    @(negedge clk);
    rst_n = 1'b1;
    busak_n = 1'b1;
    vb = 1'b0;
    repeat (2) @(negedge clk);
    fill(1);
    run_frame("post_rst", int'($urandom_range(0, 6)), 0, -1, -1, -1, 6000);
    check_full("post_rst");

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    run_frame("tmo", -1, 1, -1, -1, -1, 6000);
    chk("tmo_req_len", rq_low, TMO_CYC);
    chk("tmo_err", dma_err, 1);
    chk("tmo_done", done_cnt, 1);
    chk("tmo_busrq", busrq_n, 1);
    chk("tmo_no_we", wr_a.size(), 0);
    err_exp = 1'b1;
    fill(1);
    run_frame("post_tmo", int'($urandom_range(0, 6)), 1, -1, -1, -1, 3000);
    check_full("post_tmo");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
